// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the fetch/decode boundary:
//   XLEN, ILEN  - default pc and instruction widths
//   NOP_INSN    - canonical bubble encoding (addi x0,x0,0)
//   buf_state_e - occupancy state of the IF/ID skid buffer
//   if_id_entry_t - one pc/instruction pair as carried between the stages
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int          XLEN     = 64;
  localparam int          ILEN     = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Occupancy of the main and skid registers.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,  // nothing held
    BUF_FULL  = 2'd1,  // main valid, skid empty
    BUF_SKID  = 2'd2   // main and skid both valid
  } buf_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
  } if_id_entry_t;

endpackage : core_pkg

// File: rtl/if_id_skid_reg.sv
// -----------------------------------------------------------------------------
// if_id_skid_reg
// Single-entry valid/data register used for both the main and the skid slot of
// the IF/ID buffer.
//   clk, rst - clock, synchronous active-high reset (valid=0, data=RESET_VAL)
//   clear    - drop the entry; data is kept so the last pc stays visible
//   load     - capture d and mark the entry valid (clear wins over load)
//   d        - incoming entry
//   valid    - entry held
//   q        - held entry
// -----------------------------------------------------------------------------
module if_id_skid_reg #(
  parameter int             W         = 96,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, regardless of process order.
  // NOTE: the data field is reset too, because the main slot's reset value is
  // architecturally visible on id_pc/id_instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule : if_id_skid_reg

// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
// Pipeline buffer between fetch and decode. A 2-entry skid buffer (main + skid)
// keeps if_ready driven straight from a flop, so a decode stall never forms a
// combinational path back into fetch. flush (branch taken) empties the buffer
// and drops any incoming beat; the main register always holds the oldest entry.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - discard every held and incoming entry this cycle
//   if_valid/ready  - upstream handshake (if_ready = !skid_valid)
//   if_pc, if_instruction - fetched entry
//   id_valid/ready  - downstream handshake
//   id_pc           - pc presented to decode (holds last value during bubbles)
//   id_instruction  - instruction presented to decode, NOP_INSN when !id_valid
//
// Optional build macro IF_ID_PERF_COUNTERS_EN adds saturating 32-bit counters:
//   perf_stall_cycles, perf_flush_count, perf_bubble_cycles.
// -----------------------------------------------------------------------------
module if_id_buffer #(
  parameter int             XLEN     = core_pkg::XLEN,
  parameter int             ILEN     = core_pkg::ILEN,
  parameter logic [ILEN-1:0] NOP_INSN = core_pkg::NOP_INSN[ILEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [ILEN-1:0] if_instruction,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instruction
`ifdef IF_ID_PERF_COUNTERS_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_count,
  output logic [31:0]     perf_bubble_cycles
`endif
);

  import core_pkg::*;

  localparam int EW = XLEN + ILEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
  } entry_t;

  buf_state_e state_q, state_d;

  entry_t in_entry, main_q, skid_q, main_d;
  logic   main_valid, skid_valid;
  logic   main_load, main_clear, main_from_skid;
  logic   skid_load, skid_clear;
  logic   up_xfer, dn_xfer;

  assign in_entry = '{pc: if_pc, instruction: if_instruction};
  assign up_xfer  = if_valid && if_ready;
  assign dn_xfer  = id_valid && id_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= BUF_EMPTY;
    else     state_q <= state_d;
  end

  // Next state and slot controls.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;

    if (flush) begin
      // A beat consumed by decode this cycle stays consumed; an incoming
      // fetch beat is dropped even though if_ready may be high.
      state_d    = BUF_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (up_xfer) begin
            main_load = 1'b1;
            state_d   = BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (up_xfer && dn_xfer) begin
            main_load = 1'b1;
          end else if (up_xfer) begin
            skid_load = 1'b1;
            state_d   = BUF_SKID;
          end else if (dn_xfer) begin
            main_clear = 1'b1;
            state_d    = BUF_EMPTY;
          end
        end
        BUF_SKID: begin
          // if_ready is low here, so only the downstream side can move.
          if (dn_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = BUF_FULL;
          end
        end
        default: begin
          state_d    = BUF_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  if_id_skid_reg #(
    .W         (EW),
    .RESET_VAL ({{XLEN{1'b0}}, NOP_INSN})
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (main_clear),
    .load  (main_load),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  if_id_skid_reg #(
    .W         (EW),
    .RESET_VAL ('0)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (skid_clear),
    .load  (skid_load),
    .d     (in_entry),
    .valid (skid_valid),
    .q     (skid_q)
  );

  // if_ready comes straight from the skid valid flop.
  assign if_ready       = !skid_valid;
  assign id_valid       = main_valid;
  assign id_pc          = main_q.pc;
  assign id_instruction = main_valid ? main_q.instruction : NOP_INSN;

`ifdef IF_ID_PERF_COUNTERS_EN
  logic held_or_incoming;
  assign held_or_incoming = main_valid || skid_valid || if_valid;

  // Saturating event counters; reset dominates so nothing counts during rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles  <= '0;
      perf_flush_count   <= '0;
      perf_bubble_cycles <= '0;
    end else begin
      if (id_valid && !id_ready && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush && held_or_incoming && (perf_flush_count != 32'hFFFF_FFFF))
        perf_flush_count <= perf_flush_count + 32'd1;
      if (!id_valid && (perf_bubble_cycles != 32'hFFFF_FFFF))
        perf_bubble_cycles <= perf_bubble_cycles + 32'd1;
    end
  end
`endif

endmodule : if_id_buffer

// File: tb/tb_if_id_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_id_buffer
// Self-checking bench for if_id_buffer: a table of directed vectors, a
// hand-written flush/consume sequence, optional perf-counter checks, and a
// randomized run compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_if_id_buffer;
  import core_pkg::*;

  logic            clk = 1'b0;
  logic            rst, flush, if_valid, id_ready;
  logic            if_ready, id_valid;
  logic [XLEN-1:0] if_pc, id_pc;
  logic [ILEN-1:0] if_instruction, id_instruction;
`ifdef IF_ID_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cycles, perf_flush_count, perf_bubble_cycles;
`endif

  if_id_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instruction (id_instruction)
`ifdef IF_ID_PERF_COUNTERS_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_flush_count   (perf_flush_count),
    .perf_bubble_cycles (perf_bubble_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of at most two entries plus the last pc shown.
  if_id_entry_t    mq[$];
  logic [XLEN-1:0] last_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic f, input logic v, input logic rdy,
                       input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins);
    rst = r; flush = f; if_valid = v; id_ready = rdy; if_pc = pc; if_instruction = ins;
  endtask

  // One clock edge; the model advances with the same pre-edge inputs.
  task automatic tick();
    bit up, dn;
    if_id_entry_t e;
    up = if_valid && (mq.size() < 2);
    dn = (mq.size() > 0) && id_ready;
    e.pc = if_pc;
    e.instruction = if_instruction;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      last_pc = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (dn) void'(mq.pop_front());
      if (up) mq.push_back(e);
    end
    if (mq.size() > 0) last_pc = mq[0].pc;
  endtask

  task automatic check_model(input string tag);
    logic [XLEN-1:0] e_pc;
    logic [ILEN-1:0] e_ins;
    e_pc  = (mq.size() > 0) ? mq[0].pc : last_pc;
    e_ins = (mq.size() > 0) ? mq[0].instruction : NOP_INSN;
    check({tag, ".id_valid"}, 64'(id_valid), 64'(mq.size() > 0));
    check({tag, ".if_ready"}, 64'(if_ready), 64'(mq.size() < 2));
    check({tag, ".id_pc"}, 64'(id_pc), 64'(e_pc));
    check({tag, ".id_insn"}, 64'(id_instruction), 64'(e_ins));
  endtask

  typedef struct {
    logic            r, f, v, rdy;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ins;
    logic            e_valid, e_ready;
    logic [XLEN-1:0] e_pc;
    logic [ILEN-1:0] e_ins;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];

  initial begin
    int consumed;

    // Reset with if_valid high, then idle.
    vt[0]  = '{1, 0, 1, 0, 64'hdead, 32'h1,        0, 1, 64'h0,    NOP_INSN};
    vt[1]  = '{1, 0, 1, 0, 64'hdead, 32'h1,        0, 1, 64'h0,    NOP_INSN};
    vt[2]  = '{1, 0, 1, 0, 64'hdead, 32'h1,        0, 1, 64'h0,    NOP_INSN};
    vt[3]  = '{0, 0, 0, 1, 64'h0,    32'h0,        0, 1, 64'h0,    NOP_INSN};
    // Streaming with decode always ready.
    vt[4]  = '{0, 0, 1, 1, 64'h1000, 32'h00500093, 1, 1, 64'h1000, 32'h00500093};
    vt[5]  = '{0, 0, 1, 1, 64'h1004, 32'h00108113, 1, 1, 64'h1004, 32'h00108113};
    vt[6]  = '{0, 0, 1, 1, 64'h1008, 32'h002081B3, 1, 1, 64'h1008, 32'h002081B3};
    vt[7]  = '{0, 0, 0, 1, 64'h0,    32'h0,        0, 1, 64'h1008, NOP_INSN};
    // Backpressure fills the skid; a beat offered while full is ignored.
    vt[8]  = '{0, 0, 1, 0, 64'h2000, 32'h00100113, 1, 1, 64'h2000, 32'h00100113};
    vt[9]  = '{0, 0, 1, 0, 64'h2004, 32'h00200193, 1, 0, 64'h2000, 32'h00100113};
    vt[10] = '{0, 0, 1, 0, 64'h2008, 32'h00300213, 1, 0, 64'h2000, 32'h00100113};
    vt[11] = '{0, 0, 0, 1, 64'h0,    32'h0,        1, 1, 64'h2004, 32'h00200193};
    vt[12] = '{0, 0, 0, 1, 64'h0,    32'h0,        0, 1, 64'h2004, NOP_INSN};
    // Flush while in SKID with a new beat offered.
    vt[13] = '{0, 0, 1, 0, 64'h2100, 32'h00400293, 1, 1, 64'h2100, 32'h00400293};
    vt[14] = '{0, 0, 1, 0, 64'h2104, 32'h00500313, 1, 0, 64'h2100, 32'h00400293};
    vt[15] = '{0, 1, 1, 0, 64'h3000, 32'h00600393, 0, 1, 64'h2100, NOP_INSN};
    vt[16] = '{0, 0, 0, 1, 64'h0,    32'h0,        0, 1, 64'h2100, NOP_INSN};
    // Reset mid-operation restores id_pc = 0.
    vt[17] = '{0, 0, 1, 0, 64'h5000, 32'h00700413, 1, 1, 64'h5000, 32'h00700413};
    vt[18] = '{1, 0, 1, 0, 64'h5004, 32'h00800493, 0, 1, 64'h0,    NOP_INSN};

    apply(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < NV; i++) begin
      apply(vt[i].r, vt[i].f, vt[i].v, vt[i].rdy, vt[i].pc, vt[i].ins);
      tick();
      check($sformatf("vec%0d.id_valid", i), 64'(id_valid), 64'(vt[i].e_valid));
      check($sformatf("vec%0d.if_ready", i), 64'(if_ready), 64'(vt[i].e_ready));
      check($sformatf("vec%0d.id_pc", i), 64'(id_pc), 64'(vt[i].e_pc));
      check($sformatf("vec%0d.id_insn", i), 64'(id_instruction), 64'(vt[i].e_ins));
    end

    // Flush coinciding with a downstream transfer: 0x4000 is seen once only.
    consumed = 0;
    apply(0, 0, 1, 0, 64'h4000, 32'h00900513);
    tick();
    apply(0, 1, 0, 1, '0, '0);
    for (int c = 0; c < 4; c++) begin
      if (id_valid && id_ready && id_pc == 64'h4000) consumed++;
      tick();
      flush = 1'b0;
    end
    check("flush_dn.consumed", 64'(consumed), 64'd1);
    check_model("flush_dn");

`ifdef IF_ID_PERF_COUNTERS_EN
    apply(1, 0, 0, 0, '0, '0);
    tick();
    apply(0, 0, 1, 0, 64'h6000, 32'h00a00593);
    tick();
    apply(0, 0, 0, 0, '0, '0);
    for (int c = 0; c < 5; c++) tick();
    apply(0, 1, 0, 1, '0, '0);   // flush with an entry held
    tick();
    apply(0, 1, 1, 1, 64'h6004, 32'h0);  // flush with only an incoming beat
    tick();
    apply(0, 1, 0, 1, '0, '0);   // flush with nothing to discard
    tick();
    check("perf.stall", 64'(perf_stall_cycles), 64'd5);
    check("perf.flush", 64'(perf_flush_count), 64'd2);
    check("perf.bubble", 64'(perf_bubble_cycles), 64'd3);

    apply(1, 0, 0, 0, '0, '0);
    tick();
    apply(0, 0, 1, 0, 64'h7000, 32'h0);
    tick();
    force dut.perf_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.perf_stall_cycles;
    apply(0, 0, 0, 0, '0, '0);
    tick();
    check("perf.sat1", 64'(perf_stall_cycles), 64'hFFFF_FFFF);
    tick();
    check("perf.sat2", 64'(perf_stall_cycles), 64'hFFFF_FFFF);
`endif

    // Randomized run against the reference model.
    apply(1, 0, 0, 0, '0, '0);
    tick();
    check_model("rand_reset");
    for (int c = 0; c < 1500; c++) begin
      apply(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0, {$urandom, $urandom}, $urandom);
      tick();
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_if_id_buffer
